// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result sources, FSM states,
// load funct3 encodings and the register-file write-port bundle.
package wb_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef logic [4:0]              arch_reg_id;
    typedef logic [XLEN_DEFAULT-1:0] arch_reg;

    typedef struct packed {
        arch_reg_id addr_rd;
        logic       write_enable;
    } reg_file_write_params_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_PC4  = 2'd2,
        WB_SRC_LOAD = 2'd3
    } wb_src_t;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_extract.sv
// Combinational load data extraction: selects the byte/halfword/word
// addressed inside an aligned word, extends it, and flags bad accesses.
module load_extract
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      addr_off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] value_o,
    output logic            fault_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_off_i, 3'b000} +: 8];
        half_sel = word_i[{addr_off_i[1], 4'b0000} +: 16];
        value_o  = '0;
        fault_o  = 1'b0;
        case (funct3_i)
            F3_LB:  value_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: value_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                value_o = {{(XLEN-16){half_sel[15]}}, half_sel};
                fault_o = addr_off_i[0];
            end
            F3_LHU: begin
                value_o = {{(XLEN-16){1'b0}}, half_sel};
                fault_o = addr_off_i[0];
            end
            F3_LW: begin
                value_o = word_i;
                fault_o = |addr_off_i;
            end
            // 011 and 11x are not RV32 loads
            default: fault_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects ALU/PC+4/load result, waits for load data,
// drives the register-file write port and counts retired instructions.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int XLEN          = XLEN_DEFAULT,
    parameter int INSTRET_WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [1:0]               in_src,
    input  logic [XLEN-1:0]          in_alu_result,
    input  logic [XLEN-1:0]          in_pc_plus4,
    input  logic [2:0]               in_load_funct3,
    input  logic                     mem_rsp_valid,
    input  logic [XLEN-1:0]          mem_rsp_data,
    output logic [5:0]               write_params,
    output logic [XLEN-1:0]          data_rd,
    output logic                     load_fault,
    output logic [INSTRET_WIDTH-1:0] instret
);

    wb_state_t              state_q,    state_d;
    arch_reg_id             pend_rd_q,  pend_rd_d;
    logic [2:0]             pend_f3_q,  pend_f3_d;
    logic [1:0]             pend_off_q, pend_off_d;
    reg_file_write_params_t wp_q,       wp_d;
    logic [XLEN-1:0]        data_q,     data_d;
    logic                   fault_q,    fault_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic [XLEN-1:0] ld_value;
    logic            ld_fault;

    load_extract #(.XLEN(XLEN)) u_extract (
        .word_i     (mem_rsp_data),
        .addr_off_i (pend_off_q),
        .funct3_i   (pend_f3_q),
        .value_o    (ld_value),
        .fault_o    (ld_fault)
    );

    assign in_ready     = (state_q == WB_IDLE);
    assign write_params = wp_q;
    assign data_rd      = data_q;
    assign load_fault   = fault_q;
    assign instret      = instret_q;

    always_comb begin
        state_d           = state_q;
        pend_rd_d         = pend_rd_q;
        pend_f3_d         = pend_f3_q;
        pend_off_d        = pend_off_q;
        wp_d.addr_rd      = wp_q.addr_rd;
        wp_d.write_enable = 1'b0;
        data_d            = data_q;
        fault_d           = 1'b0;
        instret_d         = instret_q;
        case (state_q)
            WB_IDLE: begin
                if (in_valid) begin
                    if (in_src == WB_SRC_LOAD) begin
                        pend_rd_d  = in_rd;
                        pend_f3_d  = in_load_funct3;
                        pend_off_d = in_alu_result[1:0];
                        state_d    = WB_WAIT_LOAD;
                    end else begin
                        case (in_src)
                            WB_SRC_ALU: data_d = in_alu_result;
                            WB_SRC_PC4: data_d = in_pc_plus4;
                            default:    data_d = '0;
                        endcase
                        wp_d.addr_rd      = in_rd;
                        wp_d.write_enable = (in_src != WB_SRC_NONE) && (in_rd != 5'd0);
                        instret_d         = instret_q + INSTRET_WIDTH'(1);
                    end
                end
            end
            WB_WAIT_LOAD: begin
                if (mem_rsp_valid) begin
                    state_d   = WB_IDLE;
                    instret_d = instret_q + INSTRET_WIDTH'(1);
                    // A faulted load retires but leaves the last write data visible
                    if (ld_fault) begin
                        fault_d = 1'b1;
                    end else begin
                        wp_d.addr_rd      = pend_rd_q;
                        wp_d.write_enable = (pend_rd_q != 5'd0);
                        data_d            = ld_value;
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= WB_IDLE;
            pend_rd_q  <= '0;
            pend_f3_q  <= '0;
            pend_off_q <= '0;
            wp_q       <= '0;
            data_q     <= '0;
            fault_q    <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            pend_rd_q  <= pend_rd_d;
            pend_f3_q  <= pend_f3_d;
            pend_off_q <= pend_off_d;
            wp_q       <= wp_d;
            data_q     <= data_d;
            fault_q    <= fault_d;
            instret_q  <= instret_d;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed cases then random traffic
// checked against a behavioural model of completions.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_src;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [2:0]  in_load_funct3;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [5:0]  write_params;
    logic [31:0] data_rd;
    logic        load_fault;
    logic [63:0] instret;

    always #5 clock = ~clock;

    writeback_stage dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_src         (in_src),
        .in_alu_result  (in_alu_result),
        .in_pc_plus4    (in_pc_plus4),
        .in_load_funct3 (in_load_funct3),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .write_params   (write_params),
        .data_rd        (data_rd),
        .load_fault     (load_fault),
        .instret        (instret)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        fault;
        logic [63:0] instret;
    } exp_t;

    exp_t        sb_q[$];
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [63:0] m_instret;
    int          checks = 0;
    int          passes = 0;
    int          txn    = 0;
    logic [63:0] prev_instret = 64'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Reference load semantics expressed with plain arithmetic on the word
    task automatic model_load(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] word,
                              output logic [31:0] val, output logic flt);
        int unsigned off;
        int unsigned b;
        int unsigned h;
        off = addr % 4;
        b   = (word >> (8 * off)) % 256;
        h   = (word >> (16 * (off / 2))) % 65536;
        val = 32'd0;
        flt = 1'b0;
        case (f3)
            3'd0: val = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4: val = b;
            3'd1: begin val = (h >= 32768) ? h + 32'hFFFF_0000 : h; flt = (off % 2) != 0; end
            3'd5: begin val = h; flt = (off % 2) != 0; end
            3'd2: begin val = word; flt = (off != 0); end
            default: flt = 1'b1;
        endcase
    endtask

    task automatic push_exp(input logic we, input logic [4:0] rd, input logic [31:0] d,
                            input logic flt);
        exp_t e;
        m_instret++;
        if (!flt) begin
            m_addr = rd;
            m_data = d;
        end
        e.we = we; e.addr = m_addr; e.data = m_data; e.fault = flt; e.instret = m_instret;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4);
        logic [31:0] d;
        check("in_ready_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_src = src; in_rd = rd;
        in_alu_result = alu; in_pc_plus4 = pc4; in_load_funct3 = 3'($urandom);
        d = (src == 2'd1) ? alu : (src == 2'd2) ? pc4 : 32'd0;
        push_exp((src != 2'd0) && (rd != 5'd0), rd, d, 1'b0);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] word, input int delay);
        logic [31:0] v;
        logic        f;
        check("in_ready_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_src = 2'd3; in_rd = rd;
        in_alu_result = addr; in_pc_plus4 = $urandom; in_load_funct3 = f3;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_rd = 5'($urandom); in_alu_result = $urandom; in_load_funct3 = 3'($urandom);
        repeat (delay) begin
            check("in_ready_wait", 64'(in_ready), 64'd0);
            @(posedge clock); #1;
        end
        check("in_ready_wait", 64'(in_ready), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word;
        model_load(f3, addr, word, v, f);
        push_exp(!f && (rd != 5'd0), rd, v, f);
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            mem_rsp_valid = 1'($urandom_range(0, 1));
            mem_rsp_data  = $urandom;
            @(posedge clock); #1;
        end
        mem_rsp_valid = 1'b0;
    endtask

    // Monitor: every instret change must match the oldest expected completion
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            prev_instret = 64'd0;
        end else if (instret !== prev_instret) begin
            prev_instret = instret;
            txn++;
            $display("txn %0d: we=%0b rd=%0d data=0x%08h fault=%0b instret=%0d",
                     txn, write_params[0], write_params[5:1], data_rd, load_fault, instret);
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_completion: got instret %0d, required no completion", instret);
            end else begin
                e = sb_q.pop_front();
                check("write_enable", 64'(write_params[0]), 64'(e.we));
                check("addr_rd", 64'(write_params[5:1]), 64'(e.addr));
                check("data_rd", 64'(data_rd), 64'(e.data));
                check("load_fault", 64'(load_fault), 64'(e.fault));
                check("instret", instret, e.instret);
            end
        end else begin
            check("idle_write_enable", 64'(write_params[0]), 64'd0);
            check("idle_load_fault", 64'(load_fault), 64'd0);
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_src = '0;
        in_alu_result = '0; in_pc_plus4 = '0; in_load_funct3 = '0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        m_addr = '0; m_data = '0; m_instret = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_write_params", 64'(write_params), 64'd0);
        check("reset_data_rd", 64'(data_rd), 64'd0);
        check("reset_load_fault", 64'(load_fault), 64'd0);
        check("reset_instret", instret, 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;

        // ALU back-to-back
        issue(2'd1, 5'd5, 32'h0000_1234, 32'h0);
        issue(2'd1, 5'd6, 32'hFFFF_0000, 32'h0);
        check("alu_pair_instret", instret, 64'd2);
        // x0 and NONE
        issue(2'd1, 5'd0, 32'h0000_DEAD, 32'h0);
        issue(2'd0, 5'd7, 32'h1111_1111, 32'h0);
        check("x0_none_instret", instret, 64'd4);
        issue(2'd2, 5'd1, 32'h5, 32'h0000_0104);
        idle(2);

        // Load extraction
        issue_load(5'd8, 3'b000, 32'h1003, 32'h8011_2233, 3);
        check("lb_value", 64'(data_rd), 64'hFFFF_FF80);
        issue_load(5'd10, 3'b100, 32'h1003, 32'h8011_2233, 1);
        check("lbu_value", 64'(data_rd), 64'h0000_0080);
        issue_load(5'd11, 3'b001, 32'h1002, 32'h8011_2233, 0);
        check("lh_value", 64'(data_rd), 64'hFFFF_8011);
        // Misaligned LW
        issue_load(5'd9, 3'b010, 32'h1002, 32'hAAAA_AAAA, 2);
        check("lw_misaligned_fault", 64'(load_fault), 64'd1);
        check("lw_misaligned_we", 64'(write_params[0]), 64'd0);
        idle(1);

        // Reset in WAIT_LOAD; the response after reset must be ignored
        in_valid = 1'b1; in_src = 2'd3; in_rd = 5'd12;
        in_alu_result = 32'h2000; in_load_funct3 = 3'b010;
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        m_addr = '0; m_data = '0; m_instret = '0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0;
        @(posedge clock); #1;
        check("rst_load_in_ready", 64'(in_ready), 64'd1);
        check("rst_load_instret", instret, 64'd0);
        check("rst_load_we", 64'(write_params[0]), 64'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            int          kind;
            logic [4:0]  rd;
            kind = $urandom_range(0, 9);
            rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (kind < 5)
                issue(2'($urandom_range(0, 2)), rd, $urandom, $urandom);
            else if (kind < 9)
                issue_load(rd, 3'($urandom_range(0, 7)), $urandom, $urandom,
                           $urandom_range(0, 3));
            else
                idle($urandom_range(1, 3));
        end

        idle(3);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
